// File: rtl/out_regfile_drain.sv
// out_regfile_drain: walks the CONV output partial-sum register file and streams each word out on valid/ready.
// Build option OUT_DRAIN_RELU_EN: per-lane ReLU on the FIFO head before it reaches out_data.
module out_regfile_drain #(
    parameter int  Nout      = 3,
    parameter int  Pout      = 2,
    parameter int  BIT_WIDTH = 8,
    localparam int NWORDS    = (Nout + Pout - 1) / Pout,
    localparam int AW        = (NWORDS > 1) ? $clog2(NWORDS) : 1,
    localparam int DW        = Pout * BIT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rf_read_en,
    output logic [AW-1:0] rf_read_addr,
    input  logic [DW-1:0] rf_read_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last
);

    // state    | meaning
    // ST_IDLE  | waiting for start
    // ST_READ  | issuing reads, gated by FIFO credit
    // ST_FLUSH | all reads issued, draining in-flight read and FIFO
    // ST_DONE  | one-cycle done pulse
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;

    logic          rd_pend_q;
    logic [AW-1:0] pend_addr_q;
    logic          pend_last_q;

    logic [DW-1:0] fifo_data_q [2];
    logic [AW-1:0] fifo_addr_q [2];
    logic          fifo_last_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;

    logic          push;
    logic          pop;
    logic          credit_ok;
    logic [2:0]    occ_sum;
    logic [2:0]    occ_cap;
    logic [DW-1:0] head_data;

    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = rd_pend_q;

    // A new read needs a FIFO slot for itself after this cycle's pop; in-flight data already holds one.
    assign occ_sum   = {1'b0, count_q} + {2'b00, rd_pend_q} + 3'd1;
    assign occ_cap   = 3'd2 + {2'b00, pop};
    assign credit_ok = (occ_sum <= occ_cap);

    assign rf_read_addr = rd_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        rf_read_en = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_READ;
                    rd_cnt_d = '0;
                end
            end
            ST_READ: begin
                busy = 1'b1;
                if (credit_ok) begin
                    rf_read_en = 1'b1;
                    if (rd_cnt_q == LAST_ADDR) begin
                        state_d = ST_FLUSH;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                busy = 1'b1;
                // Leave as the FIFO empties, so done lands the cycle after the final handshake.
                if (!rd_pend_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                rd_cnt_d = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_last_q <= 1'b0;
        end else begin
            rd_pend_q <= rf_read_en;
            if (rf_read_en) begin
                pend_addr_q <= rd_cnt_q;
                pend_last_q <= (rd_cnt_q == LAST_ADDR);
            end
        end
    end

    // Two-entry skid FIFO; credit guarantees a push never meets a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= rf_read_data;
                fifo_addr_q[wr_ptr_q] <= pend_addr_q;
                fifo_last_q[wr_ptr_q] <= pend_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data = fifo_data_q[rd_ptr_q];
    assign out_addr  = fifo_addr_q[rd_ptr_q];
    assign out_last  = fifo_last_q[rd_ptr_q];

`ifdef OUT_DRAIN_RELU_EN
    for (genvar g = 0; g < Pout; g++) begin : g_relu
        assign out_data[g*BIT_WIDTH +: BIT_WIDTH] =
            head_data[g*BIT_WIDTH + BIT_WIDTH - 1] ? '0 : head_data[g*BIT_WIDTH +: BIT_WIDTH];
    end
`else
    assign out_data = head_data;
`endif

endmodule

// File: tb/tb_out_regfile_drain.sv
// Scoreboard bench for out_regfile_drain: a 2-word instance (Nout=3) and a 4-word instance (Nout=8).
module tb_out_regfile_drain;
    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    addr;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    always @(posedge clk) cyc++;

    logic          a_start, a_busy, a_done, a_rd_en, a_valid, a_ready, a_last;
    logic [0:0]    a_rd_addr, a_addr;
    logic [DW-1:0] a_rd_data = '0;
    logic [DW-1:0] a_data;
    logic [DW-1:0] a_rf [2];

    logic          b_start, b_busy, b_done, b_rd_en, b_valid, b_ready, b_last;
    logic [1:0]    b_rd_addr, b_addr;
    logic [DW-1:0] b_rd_data = '0;
    logic [DW-1:0] b_data;
    logic [DW-1:0] b_rf [4];

    out_regfile_drain #(.Nout(3), .Pout(2), .BIT_WIDTH(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .rf_read_en(a_rd_en), .rf_read_addr(a_rd_addr), .rf_read_data(a_rd_data),
        .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
        .out_addr(a_addr), .out_last(a_last)
    );

    out_regfile_drain #(.Nout(8), .Pout(2), .BIT_WIDTH(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .rf_read_en(b_rd_en), .rf_read_addr(b_rd_addr), .rf_read_data(b_rd_data),
        .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
        .out_addr(b_addr), .out_last(b_last)
    );

    // Register file read ports with one cycle of latency
    always @(posedge clk) if (a_rd_en) a_rd_data <= a_rf[a_rd_addr];
    always @(posedge clk) if (b_rd_en) b_rd_data <= b_rf[b_rd_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    exp_t a_q[$];
    exp_t b_q[$];
    int   a_hs = 0, a_hs_last = 0, a_hs_prev = 0, a_done_cnt = 0, a_reads = 0;
    int   b_hs = 0, b_hs_last = 0, b_done_cnt = 0, b_reads = 0;
    logic a_done_prev = 1'b0, b_done_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (a_rd_en) a_reads++;
            if (a_valid && a_ready) begin
                if (a_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_word actual=%0h expected=none", a_data);
                end else begin
                    e = a_q.pop_front();
                    check("a_data", 32'(a_data), 32'(e.data));
                    check("a_addr", 32'(a_addr), 32'(e.addr));
                    check("a_last", 32'(a_last), 32'(e.last));
                end
                a_hs++;
                a_hs_prev = a_hs_last;
                a_hs_last = cyc;
            end
            if (a_done) begin
                a_done_cnt++;
                check("a_done_timing", cyc, a_hs_last + 1);
                check("a_busy_with_done", 32'(a_busy), 32'd1);
            end
            if (a_done_prev) check("a_busy_after_done", 32'(a_busy), 32'd0);
            a_done_prev = a_done;
        end else begin
            a_done_prev = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (b_rd_en) b_reads++;
            if (b_valid && b_ready) begin
                if (b_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_word actual=%0h expected=none", b_data);
                end else begin
                    e = b_q.pop_front();
                    check("b_data", 32'(b_data), 32'(e.data));
                    check("b_addr", 32'(b_addr), 32'(e.addr));
                    check("b_last", 32'(b_last), 32'(e.last));
                end
                b_hs++;
                b_hs_last = cyc;
            end
            if (b_done) begin
                b_done_cnt++;
                check("b_done_timing", cyc, b_hs_last + 1);
            end
            if (b_done_prev) check("b_busy_after_done", 32'(b_busy), 32'd0);
            b_done_prev = b_done;
        end else begin
            b_done_prev = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_a();
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
    endtask

    task automatic push_a(input logic [DW-1:0] w0, input logic [DW-1:0] w1);
        a_q.push_back('{data: w0, addr: 2'd0, last: 1'b0});
        a_q.push_back('{data: w1, addr: 2'd1, last: 1'b1});
    endtask

    task automatic wait_idle_a(input string name);
        for (int k = 0; k < 200; k++) begin
            tick(1);
            if (!a_busy && a_q.size() == 0) break;
        end
        check({name, "_busy"}, 32'(a_busy), 32'd0);
        check({name, "_queue"}, 32'(a_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, h0;
        rst = 1'b1;
        a_start = 1'b0; a_ready = 1'b0;
        b_start = 1'b0; b_ready = 1'b0;
        a_rf[0] = 16'h0201; a_rf[1] = 16'h0003;
        b_rf[0] = 16'h0100; b_rf[1] = 16'h0302; b_rf[2] = 16'h0504; b_rf[3] = 16'h0706;
        tick(3);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_rd_en", 32'(a_rd_en), 32'd0);
        check("rst_rd_addr", 32'(a_rd_addr), 32'd0);
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_data", 32'(a_data), 32'd0);
        check("rst_addr", 32'(a_addr), 32'd0);
        check("rst_last", 32'(a_last), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        rst = 1'b0;
        tick(2);

        // 1: full-rate drain
        a_ready = 1'b1;
        push_a(16'h0201, 16'h0003);
        d0 = a_done_cnt;
        pulse_a();
        check("t1_busy", 32'(a_busy), 32'd1);
        wait_idle_a("t1");
        check("t1_done_count", a_done_cnt - d0, 32'd1);
        check("t1_back_to_back", a_hs_last - a_hs_prev, 32'd1);
        tick(2);

        // 2: stalled downstream for 5 cycles
        a_ready = 1'b0;
        push_a(16'h0201, 16'h0003);
        r0 = a_reads;
        d0 = a_done_cnt;
        pulse_a();
        tick(2);
        check("t2_valid", 32'(a_valid), 32'd1);
        check("t2_hold0", 32'(a_data), 32'h0201);
        tick(1);
        check("t2_hold1", 32'(a_data), 32'h0201);
        tick(1);
        check("t2_hold2", 32'(a_data), 32'h0201);
        check("t2_hold_addr", 32'(a_addr), 32'd0);
        check("t2_reads", a_reads - r0, 32'd2);
        a_ready = 1'b1;
        wait_idle_a("t2");
        check("t2_done_count", a_done_cnt - d0, 32'd1);
        tick(2);

        // 3: 4-word drain, stall then toggling ready
        for (int k = 0; k < 4; k++)
            b_q.push_back('{data: b_rf[k], addr: 2'(k), last: (k == 3)});
        r0 = b_reads;
        d0 = b_done_cnt;
        h0 = b_hs;
        b_start = 1'b1;
        tick(1);
        b_start = 1'b0;
        tick(4);
        check("t3_stall_reads", b_reads - r0, 32'd2);
        check("t3_stall_data", 32'(b_data), 32'h0100);
        for (int k = 0; k < 200; k++) begin
            b_ready = (k % 2 == 0);
            tick(1);
            if (!b_busy && b_q.size() == 0) break;
        end
        check("t3_busy", 32'(b_busy), 32'd0);
        check("t3_queue", 32'(b_q.size()), 32'd0);
        check("t3_words", b_hs - h0, 32'd4);
        check("t3_done_count", b_done_cnt - d0, 32'd1);
        b_ready = 1'b0;
        tick(2);

        // 4: reset mid-drain, then restart from address 0
        a_ready = 1'b0;
        push_a(16'h0201, 16'h0003);
        pulse_a();
        tick(2);
        rst = 1'b1;
        tick(1);
        check("t4_valid", 32'(a_valid), 32'd0);
        check("t4_busy", 32'(a_busy), 32'd0);
        check("t4_rd_en", 32'(a_rd_en), 32'd0);
        check("t4_data", 32'(a_data), 32'd0);
        check("t4_addr", 32'(a_addr), 32'd0);
        a_q.delete();
        rst = 1'b0;
        tick(2);
        a_ready = 1'b1;
        push_a(16'h0201, 16'h0003);
        d0 = a_done_cnt;
        pulse_a();
        wait_idle_a("t4");
        check("t4_done_count", a_done_cnt - d0, 32'd1);
        tick(2);

        // 5: start while busy is ignored
        a_ready = 1'b1;
        push_a(16'h0201, 16'h0003);
        d0 = a_done_cnt;
        h0 = a_hs;
        pulse_a();
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        wait_idle_a("t5");
        tick(5);
        check("t5_words", a_hs - h0, 32'd2);
        check("t5_done_count", a_done_cnt - d0, 32'd1);
        check("t5_idle", 32'(a_busy), 32'd0);

        // 6: negative lanes, raw or ReLU depending on build
        a_rf[0] = 16'h80FF;
        a_rf[1] = 16'h0005;
`ifdef OUT_DRAIN_RELU_EN
        push_a(16'h0000, 16'h0005);
`else
        push_a(16'h80FF, 16'h0005);
`endif
        pulse_a();
        wait_idle_a("t6");
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
